// File: rtl/serial_frame_rx_ctrl.sv
// rtl/serial_frame_rx_ctrl.sv - serial frame receiver: start-nibble hunt, payload/parity/stop capture, valid/ready output
module serial_frame_rx_ctrl #(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sIn,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {ARM, HUNT, DATA, PAR, STOP} state_t;

    state_t            state_q;
    logic [3:0]        window_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] payload_q;
    logic              par_err_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              frame_err_q;
    logic              overrun_q;
    logic              busy_q;
    logic [3:0]        window_d;

    assign window_d  = {window_q[2:0], sIn};
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARM;
            window_q    <= 4'b1111;
            bit_cnt_q   <= '0;
            payload_q   <= '0;
            par_err_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            // Consumer handshake runs regardless of en; a same-edge load below overrides it.
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (!en) begin
                state_q <= ARM;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ARM: begin
                        if (sIn) begin
                            state_q  <= HUNT;
                            window_q <= 4'b1111;
                        end
                    end
                    HUNT: begin
                        window_q <= window_d;
                        if (window_d == 4'b0000) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                            par_err_q <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                    end
                    DATA: begin
                        payload_q[bit_cnt_q] <= sIn;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_q <= PARITY_EN ? PAR : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    PAR: begin
                        par_err_q <= (^payload_q) ^ sIn;
                        state_q   <= STOP;
                    end
                    STOP: begin
                        busy_q <= 1'b0;
                        if (sIn && !par_err_q) begin
                            state_q  <= HUNT;
                            window_q <= 4'b1111;
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_q  <= payload_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            state_q     <= ARM;
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ARM;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_rx_ctrl.sv
// tb/tb_serial_frame_rx_ctrl.sv - directed self-checking bench for serial_frame_rx_ctrl
module tb_serial_frame_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       sIn = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data, p_rx_data;
    logic       rx_valid, frame_err, overrun, busy;
    logic       p_rx_valid, p_frame_err, p_overrun, p_busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int word_cnt = 0;
    logic [7:0] last_word = 8'h00;

    serial_frame_rx_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .sIn(sIn), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    serial_frame_rx_ctrl #(.DATA_W(8), .PARITY_EN(1'b1)) dut_p (
        .clk(clk), .rst(rst), .en(en), .sIn(sIn), .rx_ready(rx_ready),
        .rx_data(p_rx_data), .rx_valid(p_rx_valid), .frame_err(p_frame_err),
        .overrun(p_overrun), .busy(p_busy)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so the negedge sees what the next posedge uses.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && rx_ready) begin
                word_cnt++;
                last_word = rx_data;
            end
        end
    end

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1 sIn = b;
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic with_par, input logic par_b);
        repeat (4) send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (with_par) send_bit(par_b);
        send_bit(stop_b);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(posedge clk);
        #1 rst = 1'b1;
        idle(3);
    endtask

    task automatic test_basic();
        int w0 = word_cnt;
        int f0 = fe_cnt;
        int o0 = ov_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", rx_data); end
        idle(3);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", rx_valid); end
        checks++; if (word_cnt !== w0 + 1) begin errors++; $display("FAIL basic_words got %0d want %0d", word_cnt, w0 + 1); end
        checks++; if (fe_cnt !== f0 || ov_cnt !== o0) begin errors++; $display("FAIL basic_flags got fe=%0d ov=%0d want fe=%0d ov=%0d", fe_cnt, ov_cnt, f0, o0); end
    endtask

    task automatic test_false_start();
        int w0 = word_cnt;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(4);
        checks++; if (word_cnt !== w0 + 1) begin errors++; $display("FAIL false_start_words got %0d want %0d", word_cnt, w0 + 1); end
        checks++; if (last_word !== 8'h3C) begin errors++; $display("FAIL false_start_data got %h want 3c", last_word); end
    endtask

    task automatic test_frame_err();
        int w0 = word_cnt;
        int f0 = fe_cnt;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse got %b want 1", frame_err); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b want 0", rx_valid); end
        repeat (12) send_bit(1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stuck_low_busy got %b want 0", busy); end
        idle(3);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        idle(3);
        checks++; if (fe_cnt !== f0 + 1) begin errors++; $display("FAIL ferr_count got %0d want %0d", fe_cnt, f0 + 1); end
        checks++; if (word_cnt !== w0 + 1) begin errors++; $display("FAIL ferr_words got %0d want %0d", word_cnt, w0 + 1); end
        checks++; if (last_word !== 8'h81) begin errors++; $display("FAIL ferr_next_data got %h want 81", last_word); end
    endtask

    task automatic test_back_to_back();
        int w0 = word_cnt;
        int o0 = ov_cnt;
        int f0 = fe_cnt;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", overrun); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL b2b_hold got v=%b d=%h want v=1 d=11", rx_valid, rx_data); end
        idle(3);
        checks++; if (ov_cnt !== o0 + 1 || fe_cnt !== f0) begin errors++; $display("FAIL b2b_flags got ov=%0d fe=%0d want ov=%0d fe=%0d", ov_cnt, fe_cnt, o0 + 1, f0); end
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL b2b_data_kept got %h want 11", rx_data); end
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b want 0", rx_valid); end
        checks++; if (word_cnt !== w0 + 1 || last_word !== 8'h11) begin errors++; $display("FAIL b2b_transfer got n=%0d d=%h want n=%0d d=11", word_cnt, last_word, w0 + 1); end
        rx_ready = 1'b1;
    endtask

    task automatic test_abort();
        int w0;
        int f0;
        int o0;
        logic [7:0] d;
        rx_ready = 1'b0;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        d = 8'h5A;
        repeat (4) send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        checks++; if (busy !== 1'b1 || rx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset got busy=%b v=%b want busy=1 v=1", busy, rx_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || rx_data !== 8'h00) begin errors++; $display("FAIL async_reset got v=%b fe=%b ov=%b busy=%b d=%h want all 0", rx_valid, frame_err, overrun, busy, rx_data); end
        @(posedge clk); #1 rst = 1'b1;
        rx_ready = 1'b1;
        idle(3);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin errors++; $display("FAIL reset_resend got v=%b d=%h want v=1 d=5a", rx_valid, rx_data); end
        idle(2);
        w0 = word_cnt; f0 = fe_cnt; o0 = ov_cnt;
        repeat (4) send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        en = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_abort_busy got %b want 0", busy); end
        idle(2);
        en = 1'b1;
        idle(3);
        send_frame(8'h96, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h96) begin errors++; $display("FAIL en_next_frame got v=%b d=%h want v=1 d=96", rx_valid, rx_data); end
        idle(2);
        checks++; if (fe_cnt !== f0 || ov_cnt !== o0 || word_cnt !== w0 + 1) begin errors++; $display("FAIL en_abort_flags got fe=%0d ov=%0d n=%0d want fe=%0d ov=%0d n=%0d", fe_cnt, ov_cnt, word_cnt, f0, o0, w0 + 1); end
    endtask

    task automatic test_parity();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        idle(3);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        checks++; if (p_rx_valid !== 1'b1 || p_rx_data !== 8'h07) begin errors++; $display("FAIL parity_good got v=%b d=%h want v=1 d=07", p_rx_valid, p_rx_data); end
        checks++; if (p_frame_err !== 1'b0) begin errors++; $display("FAIL parity_good_ferr got %b want 0", p_frame_err); end
        idle(3);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++; if (p_frame_err !== 1'b1) begin errors++; $display("FAIL parity_bad_ferr got %b want 1", p_frame_err); end
        checks++; if (p_rx_valid !== 1'b0 || p_overrun !== 1'b0) begin errors++; $display("FAIL parity_bad_valid got v=%b ov=%b want v=0 ov=0", p_rx_valid, p_overrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_abort();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
